// File: rtl/ram2_arbiter_if.sv
// ram2_arbiter_if
//   CPU-side handshake bundle between the pipeline (IF and MEM stages plus
//   the pipeline controller) and the RAM2 sequencer.
//
//   Fetch port : if_req, if_addr -> if_data, if_valid
//   Data port  : mem_req, mem_we, mem_addr_i, mem_data_i -> mem_data_o, mem_done
//   Control    : stall_req (raised while any requester is waiting)
//
//   modport master : the pipeline side (drives requests)
//   modport slave  : the arbiter side (drives data/acks/stall)
interface ram2_arbiter_if #(
  parameter int DATA_W     = 16,
  parameter int CPU_ADDR_W = 16
);
  logic                  if_req;
  logic [CPU_ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0]     if_data;
  logic                  if_valid;

  logic                  mem_req;
  logic                  mem_we;
  logic [CPU_ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0]     mem_data_i;
  logic [DATA_W-1:0]     mem_data_o;
  logic                  mem_done;

  logic                  stall_req;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr_i, mem_data_i,
    input  if_data, if_valid, mem_data_o, mem_done, stall_req
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr_i, mem_data_i,
    output if_data, if_valid, mem_data_o, mem_done, stall_req
  );
endinterface

// File: rtl/ram2_arbiter.sv
// ram2_arbiter
//   Sequencer and arbiter for the single-ported RAM2 SRAM. Shares the SRAM
//   between instruction fetch and the MEM-stage data port (MEM has fixed
//   priority), runs a one-cycle read and a three-cycle write
//   (setup / pulse / hold), and requests a pipeline stall while any
//   requester is still waiting. The tristate pad lives at the top level.
//
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus        : CPU-side handshake (ram2_arbiter_if.slave)
//   sram_addr  : SRAM address pins (zero-extended CPU address)
//   sram_dq_o  : write data toward the pad; sram_dq_oe enables the pad driver
//   sram_dq_i  : read data from the pad
//   sram_ce_n, sram_oe_n, sram_we_n : active-low SRAM strobes (registered)
module ram2_arbiter #(
  parameter int DATA_W      = 16,
  parameter int CPU_ADDR_W  = 16,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  ram2_arbiter_if.slave          bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0]      sram_dq_o,
  output logic                   sram_dq_oe,
  input  logic [DATA_W-1:0]      sram_dq_i,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_t;

  state_t state;
  owner_t owner;

  // A port whose ack is high this cycle is finishing, not asking again;
  // this stops a still-held req from being re-accepted on its own ack.
  logic if_elig;
  logic mem_elig;

  assign if_elig       = bus.if_req  & ~bus.if_valid;
  assign mem_elig      = bus.mem_req & ~bus.mem_done;
  assign bus.stall_req = if_elig | mem_elig;

  function automatic logic [SRAM_ADDR_W-1:0] zext(input logic [CPU_ADDR_W-1:0] a);
    return SRAM_ADDR_W'(a);
  endfunction

  // All strobes are registered: each is set on the edge that enters the
  // state in which it must be active, so the pins never glitch.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      owner          <= OWN_IF;
      sram_addr      <= '0;
      sram_dq_o      <= '0;
      sram_dq_oe     <= 1'b0;
      sram_ce_n      <= 1'b1;
      sram_oe_n      <= 1'b1;
      sram_we_n      <= 1'b1;
      bus.if_data    <= '0;
      bus.if_valid   <= 1'b0;
      bus.mem_data_o <= '0;
      bus.mem_done   <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.mem_done <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (mem_elig) begin
            owner     <= OWN_MEM;
            sram_addr <= zext(bus.mem_addr_i);
            sram_ce_n <= 1'b0;
            if (bus.mem_we) begin
              sram_dq_o  <= bus.mem_data_i;
              sram_dq_oe <= 1'b1;
              state      <= S_WR_SETUP;
            end else begin
              sram_oe_n <= 1'b0;
              state     <= S_RD;
            end
          end else if (if_elig) begin
            owner     <= OWN_IF;
            sram_addr <= zext(bus.if_addr);
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            state     <= S_RD;
          end
        end

        S_RD: begin
          if (owner == OWN_IF) begin
            bus.if_data  <= sram_dq_i;
            bus.if_valid <= 1'b1;
          end else begin
            bus.mem_data_o <= sram_dq_i;
            bus.mem_done   <= 1'b1;
          end
          sram_oe_n <= 1'b1;
          sram_ce_n <= 1'b1;
          state     <= S_IDLE;
        end

        S_WR_SETUP: begin
          sram_we_n <= 1'b0;
          state     <= S_WR_PULSE;
        end

        // Address and data stay registered through the hold cycle so the
        // SRAM sees them stable around the rising edge of we_n.
        S_WR_PULSE: begin
          sram_we_n <= 1'b1;
          state     <= S_WR_HOLD;
        end

        S_WR_HOLD: begin
          sram_dq_oe   <= 1'b0;
          sram_ce_n    <= 1'b1;
          bus.mem_done <= 1'b1;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram2_arbiter.sv
// tb_ram2_arbiter
//   Self-checking bench for ram2_arbiter: a behavioural SRAM on the pins,
//   a reference memory image, and per-port scoreboard queues of expected
//   completions that are popped whenever the DUT acks.
module tb_ram2_arbiter;
  localparam int DATA_W      = 16;
  localparam int CPU_ADDR_W  = 16;
  localparam int SRAM_ADDR_W = 18;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] data;
  } mem_exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0]      sram_dq_o;
  logic [DATA_W-1:0]      sram_dq_i;
  logic                   sram_dq_oe;
  logic                   sram_ce_n;
  logic                   sram_oe_n;
  logic                   sram_we_n;

  ram2_arbiter_if #(.DATA_W(DATA_W), .CPU_ADDR_W(CPU_ADDR_W)) bus ();

  ram2_arbiter #(
    .DATA_W(DATA_W), .CPU_ADDR_W(CPU_ADDR_W), .SRAM_ADDR_W(SRAM_ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic [DATA_W-1:0]     sram_mem [0:(1<<SRAM_ADDR_W)-1];
  logic [DATA_W-1:0]     ref_mem  [0:(1<<CPU_ADDR_W)-1];
  logic                  pl_en = 1'b0;
  logic [CPU_ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0]     pl_data;
  int                    we_low_cnt = 0;

  always @(posedge clk) begin
    if (pl_en)
      sram_mem[SRAM_ADDR_W'(pl_addr)] <= pl_data;
    else if (!sram_ce_n && !sram_we_n && sram_dq_oe)
      sram_mem[sram_addr] <= sram_dq_o;
    if (!sram_we_n) we_low_cnt <= we_low_cnt + 1;
  end

  always_comb begin
    sram_dq_i = 16'hDEAD;
    if (!sram_ce_n && !sram_oe_n && !sram_dq_oe) sram_dq_i = sram_mem[sram_addr];
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] if_q [$];
  mem_exp_t          mem_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.if_valid) begin
        if (if_q.size() == 0) check("if_unexpected_valid", 1, 0);
        else check("if_data", bus.if_data, if_q.pop_front());
      end
      if (bus.mem_done) begin
        if (mem_q.size() == 0) check("mem_unexpected_done", 1, 0);
        else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          if (!e.we) check("mem_data_o", bus.mem_data_o, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic preload(input logic [CPU_ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_done(input bit port_if, input int budget, output int lat);
    bit hit;
    lat = 0; hit = 1'b0;
    while (!hit && lat < budget) begin
      @(negedge clk);
      lat++;
      hit = port_if ? bus.if_valid : bus.mem_done;
    end
    if (!hit) check(port_if ? "if_timeout" : "mem_timeout", 0, 1);
  endtask

  task automatic mem_access(input bit we, input logic [CPU_ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    int       lat;
    mem_exp_t e;
    @(negedge clk);
    bus.mem_we = we; bus.mem_addr_i = a; bus.mem_data_i = d; bus.mem_req = 1'b1;
    e.we = we;
    e.data = we ? d : ref_mem[a];
    mem_q.push_back(e);
    if (we) ref_mem[a] = d;
    wait_done(1'b0, 10, lat);
    check(we ? "mem_wr_latency" : "mem_rd_latency", lat, we ? 4 : 2);
    bus.mem_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int       lat;
    int       wcnt0;
    mem_exp_t e;
    logic [CPU_ADDR_W-1:0] a;
    logic [DATA_W-1:0]     d;

    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr_i = '0; bus.mem_data_i = '0;

    // Preloading happens while reset is held (well over two cycles).
    preload(16'h0010, 16'h4A21);
    preload(16'h0020, 16'h1111);
    preload(16'h0030, 16'h3030);
    preload(16'h0040, 16'h5555);
    for (int i = 0; i < 8; i++) preload(16'h0100 + 16'(i), 16'hC000 + 16'(i * 16'h0111));

    // Reset state
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst_ce_n",   sram_ce_n, 1);
    check("rst_oe_n",   sram_oe_n, 1);
    check("rst_we_n",   sram_we_n, 1);
    check("rst_dq_oe",  sram_dq_oe, 0);
    check("rst_addr",   sram_addr, 0);
    check("rst_dq_o",   sram_dq_o, 0);
    check("rst_valid",  bus.if_valid, 0);
    check("rst_done",   bus.mem_done, 0);
    check("rst_if_data", bus.if_data, 0);
    check("rst_mem_data", bus.mem_data_o, 0);
    check("rst_stall",  bus.stall_req, 0);

    // Single fetch
    @(negedge clk);
    bus.if_addr = 16'h0010; bus.if_req = 1'b1; if_q.push_back(16'h4A21);
    #1 check("f_stall_c0", bus.stall_req, 1);
    @(negedge clk);
    check("f_addr_c1",  sram_addr, 18'h00010);
    check("f_oe_n_c1",  sram_oe_n, 0);
    check("f_ce_n_c1",  sram_ce_n, 0);
    check("f_stall_c1", bus.stall_req, 1);
    check("f_valid_c1", bus.if_valid, 0);
    @(negedge clk);
    check("f_valid_c2", bus.if_valid, 1);
    check("f_stall_c2", bus.stall_req, 0);
    bus.if_req = 1'b0;

    // Write 0xBEEF to 0x0123, cycle by cycle
    @(negedge clk);
    wcnt0 = we_low_cnt;
    bus.mem_addr_i = 16'h0123; bus.mem_data_i = 16'hBEEF; bus.mem_we = 1'b1; bus.mem_req = 1'b1;
    e.we = 1'b1; e.data = 16'hBEEF; mem_q.push_back(e);
    ref_mem[16'h0123] = 16'hBEEF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("wr_we_n_c%0d", c),  sram_we_n, (c != 2));
      check($sformatf("wr_dq_oe_c%0d", c), sram_dq_oe, (c <= 3));
      check($sformatf("wr_done_c%0d", c),  bus.mem_done, (c == 4));
      if (c <= 3) begin
        check($sformatf("wr_addr_c%0d", c), sram_addr, 18'h00123);
        check($sformatf("wr_dq_o_c%0d", c), sram_dq_o, 16'hBEEF);
      end
    end
    bus.mem_req = 1'b0;
    check("wr_one_pulse", we_low_cnt, wcnt0 + 1);
    mem_access(1'b0, 16'h0123, '0);

    // Contention: MEM read and fetch raised together
    @(negedge clk);
    bus.if_addr = 16'h0020; bus.if_req = 1'b1; if_q.push_back(ref_mem[16'h0020]);
    bus.mem_addr_i = 16'h0030; bus.mem_we = 1'b0; bus.mem_req = 1'b1;
    e.we = 1'b0; e.data = ref_mem[16'h0030]; mem_q.push_back(e);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("ct_done_c%0d", c),  bus.mem_done, (c == 2));
      check($sformatf("ct_valid_c%0d", c), bus.if_valid, (c == 4));
      if (c == 1) check("ct_addr_mem_rd", sram_addr, 18'h00030);
      if (c == 3) check("ct_addr_if_rd",  sram_addr, 18'h00020);
      if (c == 2) bus.mem_req = 1'b0;
    end
    bus.if_req = 1'b0;

    // Reset asserted during WR_SETUP
    @(negedge clk);
    wcnt0 = we_low_cnt;
    bus.mem_addr_i = 16'h0040; bus.mem_data_i = 16'h1234; bus.mem_we = 1'b1; bus.mem_req = 1'b1;
    @(negedge clk);
    check("rmw_setup_dq_oe", sram_dq_oe, 1);
    rst = 1'b1; bus.mem_req = 1'b0;
    @(negedge clk);
    check("rmw_we_n",  sram_we_n, 1);
    check("rmw_dq_oe", sram_dq_oe, 0);
    check("rmw_ce_n",  sram_ce_n, 1);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rmw_no_done", bus.mem_done, 0);
      check("rmw_idle_ce_n", sram_ce_n, 1);
    end
    check("rmw_no_pulse", we_low_cnt, wcnt0);
    mem_access(1'b0, 16'h0040, '0);

    // Continuous fetch, one if_valid every 3 cycles
    @(negedge clk);
    bus.if_addr = 16'h0100; bus.if_req = 1'b1; if_q.push_back(ref_mem[16'h0100]);
    for (int k = 0; k < 8; k++) begin
      wait_done(1'b1, 6, lat);
      check($sformatf("fetch_gap_%0d", k), lat, (k == 0) ? 2 : 3);
      if (k < 7) begin
        bus.if_addr = bus.if_addr + 16'd1;
        if_q.push_back(ref_mem[bus.if_addr]);
      end else begin
        bus.if_req = 1'b0;
      end
    end

    // Top CPU address: zero extension onto the 18-bit pins
    mem_access(1'b1, 16'hFFFF, 16'h7E57);
    @(negedge clk);
    bus.if_addr = 16'hFFFF; bus.if_req = 1'b1; if_q.push_back(ref_mem[16'hFFFF]);
    @(negedge clk);
    check("top_addr_zext", sram_addr, 18'h0FFFF);
    wait_done(1'b1, 4, lat);
    check("top_fetch_latency", lat, 1);
    bus.if_req = 1'b0;

    // Random write/read-back pairs
    for (int i = 0; i < 4; i++) begin
      a = 16'h0200 + 16'($urandom_range(0, 255));
      d = 16'($urandom);
      mem_access(1'b1, a, d);
      mem_access(1'b0, a, '0);
    end

    repeat (3) @(negedge clk);
    check("if_q_drained",  if_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram2_arbiter.md
# ram2_arbiter

Sequencer and arbiter for the single-ported external RAM2 SRAM. It shares RAM2 between the instruction-fetch port (pc) and the MEM-stage data port, and drives the SRAM control strobes with a multi-cycle write protocol. It raises a stall request to the pipeline controller while any requester is waiting. It replaces the direct combinational RAM2 hookup between the IF/MEM stages and the board SRAM pins. The tristate data pad sits at the top level.

## Interface
Parameters:
- DATA_W, 16, width of the SRAM and CPU data word
- CPU_ADDR_W, 16, width of CPU addresses (pc, mem_addr_i)
- SRAM_ADDR_W, 18, width of the SRAM address pins

Ports:
- clk  in  1  system clock; everything updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  CPU_ADDR_W  fetch address (pc)
- if_data  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle fetch-complete pulse
- mem_req  in  1  data access request; held high until mem_done
- mem_we  in  1  1 = write, 0 = read; stable while mem_req is high
- mem_addr_i  in  CPU_ADDR_W  data address
- mem_data_i  in  DATA_W  write data
- mem_data_o  out  DATA_W  read data
- mem_done  out  1  one-cycle data-complete pulse (read or write)
- stall_req  out  1  pipeline stall request
- sram_addr  out  SRAM_ADDR_W  SRAM address pins
- sram_dq_o  out  DATA_W  data driven toward the pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_i  in  DATA_W  data from the pad
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- Owner register: IF or MEM.
- In IDLE the block selects one eligible requester. A requester is eligible if its req is high and its own ack is not high this cycle. MEM has fixed priority over IF.
  - MEM read or IF fetch goes to RD.
  - MEM write goes to WR_SETUP.
  - If nothing is eligible, the block stays in IDLE.
- On acceptance the block registers:
  - sram_addr = zero-extended CPU address
  - sram_ce_n = 0
  - the owner
  - for writes, sram_dq_o = mem_data_i
- RD state:
  - sram_oe_n = 0, sram_we_n = 1, sram_dq_oe = 0.
  - At the end of the cycle, sram_dq_i is captured into if_data or mem_data_o according to the owner.
  - Next state is IDLE, with that owner's ack high for that one cycle.
- WR_SETUP: sram_dq_oe = 1, oe_n = 1, we_n = 1.
- WR_PULSE: we_n = 0.
- WR_HOLD: we_n = 1, with dq_oe and address still held.
- WR_HOLD then goes to IDLE with mem_done high.
- sram_ce_n = 1 and sram_dq_oe = 0 in IDLE.
- Address and data remain stable from WR_SETUP through WR_HOLD.
- if_data and mem_data_o hold their last value until the next completion for the same port.
- stall_req (combinational) = (if_req & ~if_valid) | (mem_req & ~mem_done).
- Reset: state = IDLE, and the pending access is abandoned with no ack. All outputs reset as follows:
  - sram_ce_n = sram_oe_n = sram_we_n = 1
  - sram_dq_oe = 0
  - sram_addr = 0, sram_dq_o = 0
  - if_data = mem_data_o = 0
  - if_valid = mem_done = 0
  - stall_req follows its equation

## Timing
- Read latency: req sampled at edge 0 → RD in cycle 1 → if_valid or mem_done high in cycle 2, with data valid in that same cycle.
- Write: accepted at cycle 0 → WR_SETUP in cycle 1 → WR_PULSE in cycle 2 → WR_HOLD in cycle 3 → mem_done in cycle 4.
- Same-port back-to-back: ack at cycle n, next access for that port accepted at cycle n+1 at the earliest.
- The other port may be accepted in the ack cycle itself.
- Simultaneous if_req and mem_req: MEM is served first. IF is accepted in MEM's ack cycle, so for a MEM read if_valid lands 2 cycles after mem_done.
- A request that arrives mid-operation waits; it is never preempted.
- Reset asserted mid-write: we_n returns high and dq_oe low on the next edge.
- Requests dropped before their ack: behaviour is undefined, and the bench must not do this.

## Test plan
- Reset: hold rst 2 cycles, then release → all strobes 1, dq_oe 0, acks 0, data outputs 0.
- Fetch: if_req, if_addr = 0x0010, SRAM model word 0x4A21 → sram_addr = 0x00010 in cycle 1, oe_n low in cycle 1, if_valid and if_data = 0x4A21 in cycle 2, stall_req high in cycles 0-1.
- Write then read: mem write 0xBEEF to 0x0123 → we_n low only in cycle 2, mem_done in cycle 4. Follow-up read of 0x0123 → mem_data_o = 0xBEEF.
- Contention: if_req and mem_req (read) both raised at cycle 0 → mem_done at cycle 2, if_valid at cycle 4, sram_addr never changes during RD.
- Reset mid-write: rst asserted during WR_SETUP → no we_n low pulse, no mem_done, state IDLE.
- Continuous fetch: if_req held high with the address incrementing each ack → one if_valid every 3 cycles with correct data sequence.
